send_scheduler: RTL and testbench
=================================

SEND_SCHEDULER -- requirements
Module: send_scheduler

Interface
REQ-001 SHALL provide parameters (name, default, meaning):
- SEG_W, 16, segment index width
- ID_W, 8, copy index (txid) width
- AUX_W, 8, sweep counter width
- CNT_W, 28, inter-frame gap counter width
REQ-002 SHALL provide ports (name, direction, width, meaning):
- clk125MHz, in, 1, sole clock
- RST, in, 1, asynchronous active-high reset
- enable, in, 1, free-run permission
- frame_sync_mode, in, 1, 1 = one cycle per start_frame; 0 = free-run
- start_frame, in, 1, one-cycle trigger (frame_sync_mode only)
- abort, in, 1, cancel current cycle
- mode, in, 1, 0 = sweep-major (all segments per copy); 1 = segment-major (all copies per segment)
- gap_count, in, CNT_W, idle cycles between issues
- segment_num_max, in, SEG_W, last segment index
- redundancy, in, ID_W, copies per segment (0 treated as 1)
- busy, in, 1, transmitter occupied
- start_sending, out, 1, one-cycle send request
- segment_num_out, out, SEG_W, segment index of the current request
- txid_out, out, ID_W, copy index of the current request, 1-based
- aux_out, out, AUX_W, sweep counter of the current request
- cycle_done, out, 1, one-cycle pulse at cycle wrap
- active, out, 1, high when not IDLE

Function
REQ-003 SHALL implement states IDLE, GAP, ISSUE and ADVANCE.
REQ-004 IDLE->GAP SHALL occur when busy=0 and either (frame_sync_mode=0 and enable=1) or (frame_sync_mode=1 and start_frame=1); this transition clears seg, txid and the gap counter.
REQ-005 SHALL latch mode, gap_count, segment_num_max and redundancy on IDLE->GAP and at every cycle wrap; mid-cycle input changes SHALL have no effect.
REQ-006 GAP behaviour SHALL be:
- busy=1: counter cleared to 0
- busy=0 and counter==gap_count: go to ISSUE
- otherwise: counter increments
REQ-007 ISSUE SHALL last one cycle and assert start_sending (Moore output) with segment_num_out, txid_out and aux_out driven from internal seg, txid and aux; these outputs SHALL hold until the next ISSUE.
REQ-008 ISSUE->ADVANCE SHALL be unconditional; ADVANCE SHALL last one cycle, ignore busy and update indices.
REQ-009 Sweep-major advance (mode=0) SHALL be:
- seg<max: seg+1
- else: seg=0; then if txid<R, txid+1, else txid=1 with a wrap
REQ-010 Segment-major advance (mode=1) SHALL be:
- txid<R: txid+1
- else: txid=1; then if seg<max, seg+1, else seg=0 with a wrap
REQ-011 On wrap: aux SHALL increment modulo 2^AUX_W and cycle_done SHALL pulse during the cycle after ADVANCE.
REQ-012 After ADVANCE the next state SHALL be:
- IDLE if wrap and frame_sync_mode=1
- IDLE if enable=0 and frame_sync_mode=0
- GAP otherwise, with the counter cleared
REQ-013 abort SHALL have priority over everything: in any state, the next state is IDLE, start_sending=0, seg=0, txid=1, aux unchanged and no cycle_done.
REQ-014 abort and start_frame in the same cycle SHALL resolve to abort.
REQ-015 start_frame outside IDLE SHALL be ignored.
REQ-016 Latency SHALL be: start_frame sampled in IDLE with busy=0 throughout gives start_sending exactly gap_count+2 cycles later.
REQ-017 Issue spacing with busy=0 SHALL be gap_count+3 cycles.
REQ-018 segment_num_max=0 SHALL give a single segment per copy; gap_count=0 SHALL give issue on the first GAP cycle with busy=0.

Reset
REQ-019 RST=1 SHALL immediately force:
- state = IDLE
- start_sending = cycle_done = active = 0
- segment_num_out = 0
- txid_out = 1
- aux_out = 0
- gap counter = 0
REQ-020 Reset mid-ISSUE SHALL truncate start_sending asynchronously.
REQ-021 Operation SHALL resume only per REQ-004 after RST deasserts.

Verification
REQ-022 Sweep-major: max=2, R=2, gap=0, free-run -> (seg,txid) = (0,1)(1,1)(2,1)(0,2)(1,2)(2,2); cycle_done after the 6th issue; aux 0 then 1.
REQ-023 Segment-major: same settings -> (0,1)(0,2)(1,1)(1,2)(2,1)(2,2).
REQ-024 Frame-sync: gap=5, start_frame at cycle 10 -> start_sending at cycle 17; IDLE after wrap; no issue without a new start_frame.
REQ-025 Busy stall: gap=3, busy high for 4 cycles mid-GAP -> counter restarts; issue 4 busy-free GAP cycles after busy falls.
REQ-026 Abort during GAP of the 3rd issue, with start_frame in the same cycle -> IDLE; next cycle restarts at (0,1) with aux unchanged.
REQ-027 R=0 with aux=255 at wrap -> behaves as R=1; aux wraps to 0; cycle_done pulses.

Source files
------------

// File: rtl/send_scheduler.sv
// ---------------------------------------------------------------------------
// send_scheduler
//
// Paces transmit requests over a two-level index space (segment x copy).
// Each request is preceded by a programmable idle gap. Segments and copies
// are walked either sweep-major (all segments of one copy, then the next
// copy) or segment-major (all copies of one segment, then the next segment).
// The scheduler runs either continuously while enabled or for exactly one
// full sweep per start_frame trigger.
//
// Ports
//   clk125MHz        in   sole clock
//   RST              in   asynchronous active-high reset
//   enable           in   free-run permission
//   frame_sync_mode  in   1: one sweep per start_frame, 0: free-run
//   start_frame      in   one-cycle trigger, honoured only in IDLE
//   abort            in   cancel the current sweep, return to IDLE
//   mode             in   0: sweep-major, 1: segment-major
//   gap_count        in   idle cycles between requests
//   segment_num_max  in   last segment index
//   redundancy       in   copies per segment (0 behaves as 1)
//   busy             in   transmitter occupied, restarts the gap
//   start_sending    out  one-cycle send request
//   segment_num_out  out  segment index of the last request
//   txid_out         out  copy index of the last request (1-based)
//   aux_out          out  sweep counter of the last request
//   cycle_done       out  one-cycle pulse after a sweep wraps
//   active           out  high whenever the scheduler is not IDLE
// ---------------------------------------------------------------------------
module send_scheduler #(
    parameter int SEG_W = 16,
    parameter int ID_W  = 8,
    parameter int AUX_W = 8,
    parameter int CNT_W = 28
) (
    input  logic             clk125MHz,
    input  logic             RST,
    input  logic             enable,
    input  logic             frame_sync_mode,
    input  logic             start_frame,
    input  logic             abort,
    input  logic             mode,
    input  logic [CNT_W-1:0] gap_count,
    input  logic [SEG_W-1:0] segment_num_max,
    input  logic [ID_W-1:0]  redundancy,
    input  logic             busy,
    output logic             start_sending,
    output logic [SEG_W-1:0] segment_num_out,
    output logic [ID_W-1:0]  txid_out,
    output logic [AUX_W-1:0] aux_out,
    output logic             cycle_done,
    output logic             active
);

    typedef enum logic [1:0] {
        IDLE,
        GAP,
        ISSUE,
        ADVANCE
    } state_t;

    state_t           state_q;
    logic [SEG_W-1:0] seg_q;
    logic [ID_W-1:0]  txid_q;
    logic [AUX_W-1:0] aux_q;
    logic [CNT_W-1:0] cnt_q;

    // Configuration snapshot, refreshed only at sweep boundaries so that
    // mid-sweep input changes cannot tear the index sequence.
    logic             mode_q;
    logic [CNT_W-1:0] gap_q;
    logic [SEG_W-1:0] max_q;
    logic [ID_W-1:0]  red_q;

    logic             start_sending_q;
    logic [SEG_W-1:0] seg_out_q;
    logic [ID_W-1:0]  txid_out_q;
    logic [AUX_W-1:0] aux_out_q;
    logic             cycle_done_q;

    // Index update applied in ADVANCE
    logic [SEG_W-1:0] seg_d;
    logic [ID_W-1:0]  txid_d;
    logic             wrap_d;
    logic [ID_W-1:0]  red_eff;
    logic             seg_last;
    logic             txid_last;
    logic             start_ok;

    assign start_ok = !busy && (frame_sync_mode ? start_frame : enable);

    always_comb begin
        // NOTE: every signal gets a default before any branch, otherwise an
        // untaken path holds its old value and a latch is inferred.
        red_eff   = (red_q == '0) ? ID_W'(1) : red_q;
        seg_last  = (seg_q >= max_q);
        txid_last = (txid_q >= red_eff);
        seg_d     = seg_q;
        txid_d    = txid_q;
        wrap_d    = 1'b0;
        if (!mode_q) begin
            // Sweep-major: segment is the inner index
            if (!seg_last) begin
                seg_d = seg_q + SEG_W'(1);
            end else begin
                seg_d = '0;
                if (!txid_last) begin
                    txid_d = txid_q + ID_W'(1);
                end else begin
                    txid_d = ID_W'(1);
                    wrap_d = 1'b1;
                end
            end
        end else begin
            // Segment-major: copy is the inner index
            if (!txid_last) begin
                txid_d = txid_q + ID_W'(1);
            end else begin
                txid_d = ID_W'(1);
                if (!seg_last) begin
                    seg_d = seg_q + SEG_W'(1);
                end else begin
                    seg_d  = '0;
                    wrap_d = 1'b1;
                end
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments only, so every
    // right-hand side below reads the value from before this clock edge.
    always_ff @(posedge clk125MHz or posedge RST) begin
        if (RST) begin
            // NOTE: every flop, including the configuration snapshot, has a
            // defined reset value; none of this is RAM so there is no cost.
            state_q         <= IDLE;
            seg_q           <= '0;
            txid_q          <= ID_W'(1);
            aux_q           <= '0;
            cnt_q           <= '0;
            mode_q          <= 1'b0;
            gap_q           <= '0;
            max_q           <= '0;
            red_q           <= '0;
            start_sending_q <= 1'b0;
            seg_out_q       <= '0;
            txid_out_q      <= ID_W'(1);
            aux_out_q       <= '0;
            cycle_done_q    <= 1'b0;
        end else begin
            start_sending_q <= 1'b0;
            cycle_done_q    <= 1'b0;
            if (abort) begin
                // Abort wins over every transition; aux is kept on purpose
                state_q <= IDLE;
                seg_q   <= '0;
                txid_q  <= ID_W'(1);
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start_ok) begin
                            state_q <= GAP;
                            seg_q   <= '0;
                            txid_q  <= ID_W'(1);
                            cnt_q   <= '0;
                            mode_q  <= mode;
                            gap_q   <= gap_count;
                            max_q   <= segment_num_max;
                            red_q   <= redundancy;
                        end
                    end
                    GAP: begin
                        if (busy) begin
                            cnt_q <= '0;
                        end else if (cnt_q == gap_q) begin
                            // Request fields are captured on entry so they
                            // hold steady until the next request.
                            state_q         <= ISSUE;
                            start_sending_q <= 1'b1;
                            seg_out_q       <= seg_q;
                            txid_out_q      <= txid_q;
                            aux_out_q       <= aux_q;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    ISSUE: begin
                        state_q <= ADVANCE;
                    end
                    ADVANCE: begin
                        seg_q  <= seg_d;
                        txid_q <= txid_d;
                        cnt_q  <= '0;
                        if (wrap_d) begin
                            aux_q        <= aux_q + AUX_W'(1);
                            cycle_done_q <= 1'b1;
                            mode_q       <= mode;
                            gap_q        <= gap_count;
                            max_q        <= segment_num_max;
                            red_q        <= redundancy;
                        end
                        if ((wrap_d && frame_sync_mode) || (!enable && !frame_sync_mode)) begin
                            state_q <= IDLE;
                        end else begin
                            state_q <= GAP;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign start_sending   = start_sending_q;
    assign segment_num_out = seg_out_q;
    assign txid_out        = txid_out_q;
    assign aux_out         = aux_out_q;
    assign cycle_done      = cycle_done_q;
    assign active          = (state_q != IDLE);

endmodule

// File: tb/tb_send_scheduler.sv
// ---------------------------------------------------------------------------
// tb_send_scheduler
//
// Directed bench for send_scheduler. Inputs change on the falling edge and
// outputs are sampled on the falling edge, half a period from the rising
// edge the design uses. Expected values are hand-derived index sequences
// and cycle distances counted in rising edges.
// ---------------------------------------------------------------------------
module tb_send_scheduler;

    localparam int SEG_W = 16;
    localparam int ID_W  = 8;
    localparam int AUX_W = 8;
    localparam int CNT_W = 28;

    logic             clk125MHz = 1'b0;
    logic             RST = 1'b1;
    logic             enable = 1'b0;
    logic             frame_sync_mode = 1'b0;
    logic             start_frame = 1'b0;
    logic             abort = 1'b0;
    logic             mode = 1'b0;
    logic [CNT_W-1:0] gap_count = '0;
    logic [SEG_W-1:0] segment_num_max = '0;
    logic [ID_W-1:0]  redundancy = '0;
    logic             busy = 1'b0;
    logic             start_sending;
    logic [SEG_W-1:0] segment_num_out;
    logic [ID_W-1:0]  txid_out;
    logic [AUX_W-1:0] aux_out;
    logic             cycle_done;
    logic             active;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    send_scheduler #(
        .SEG_W(SEG_W),
        .ID_W (ID_W),
        .AUX_W(AUX_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk125MHz      (clk125MHz),
        .RST            (RST),
        .enable         (enable),
        .frame_sync_mode(frame_sync_mode),
        .start_frame    (start_frame),
        .abort          (abort),
        .mode           (mode),
        .gap_count      (gap_count),
        .segment_num_max(segment_num_max),
        .redundancy     (redundancy),
        .busy           (busy),
        .start_sending  (start_sending),
        .segment_num_out(segment_num_out),
        .txid_out       (txid_out),
        .aux_out        (aux_out),
        .cycle_done     (cycle_done),
        .active         (active)
    );

    always #4 clk125MHz = ~clk125MHz;

    // Rising-edge counter used to measure latencies and spacing
    always @(posedge clk125MHz) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(negedge clk125MHz);
    endtask

    task automatic tick_n(input int n);
        repeat (n) tick();
    endtask

    // Advances at least one cycle, then stops on the first cycle with a request
    task automatic wait_issue(input string tag);
        int k;
        k = 0;
        do begin
            tick();
            k++;
        end while (!start_sending && k < 300);
        if (!start_sending) check({tag, "_timeout"}, int'(start_sending), 1);
    endtask

    task automatic check_issue(input string tag, input int s, input int t, input int a);
        check({tag, "_seg"},  int'(segment_num_out), s);
        check({tag, "_txid"}, int'(txid_out), t);
        check({tag, "_aux"},  int'(aux_out), a);
    endtask

    task automatic set_cfg(input logic m, input int gap, input int smax, input int red);
        mode            = m;
        gap_count       = CNT_W'(gap);
        segment_num_max = SEG_W'(smax);
        redundancy      = ID_W'(red);
    endtask

    initial begin
        int last;
        int c0;
        int n;
        bit ok;

        // ---------------- reset state ----------------
        tick_n(2);
        check("rst_start_sending", int'(start_sending), 0);
        check("rst_cycle_done", int'(cycle_done), 0);
        check("rst_active", int'(active), 0);
        check_issue("rst", 0, 1, 0);

        // ---------------- sweep-major, free-run ----------------
        set_cfg(1'b0, 0, 2, 2);
        frame_sync_mode = 1'b0;
        RST = 1'b0;
        tick();
        check("idle_without_enable", int'(active), 0);
        enable = 1'b1;
        last = 0;
        for (int i = 0; i < 6; i++) begin
            wait_issue("sm");
            check_issue("sm", i % 3, i / 3 + 1, 0);
            if (i > 0) check("sm_spacing", cyc - last, 3);
            last = cyc;
            tick_n(2);
            check("sm_cycle_done", int'(cycle_done), (i == 5) ? 1 : 0);
        end
        wait_issue("sm7");
        check_issue("sm7", 0, 1, 1);
        enable = 1'b0;
        tick_n(3);
        check("sm_stop_idle", int'(active), 0);

        // ---------- segment-major; mid-sweep config changes ignored ----------
        set_cfg(1'b1, 0, 2, 2);
        enable = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wait_issue("gm");
            check_issue("gm", i / 2, i % 2 + 1, 1);
            if (i > 0) check("gm_spacing", cyc - last, 3);
            last = cyc;
            if (i == 0) set_cfg(1'b0, 9, 7, 5);
            if (i == 5) enable = 1'b0;
        end
        tick_n(2);
        check("gm_cycle_done", int'(cycle_done), 1);
        check("gm_stop_idle", int'(active), 0);

        // ---------- frame-sync: latency gap+2, one sweep per trigger ----------
        set_cfg(1'b0, 5, 0, 1);
        frame_sync_mode = 1'b1;
        start_frame = 1'b1;
        c0 = cyc;
        tick();
        start_frame = 1'b0;
        tick();
        start_frame = 1'b1;   // lands in GAP and must be ignored
        tick();
        start_frame = 1'b0;
        wait_issue("fs");
        check("fs_latency", cyc - c0, 7);
        check_issue("fs", 0, 1, 2);
        tick_n(2);
        check("fs_cycle_done", int'(cycle_done), 1);
        check("fs_idle_after_wrap", int'(active), 0);
        n = 0;
        repeat (20) begin
            tick();
            if (start_sending) n++;
        end
        check("fs_no_reissue", n, 0);

        // ---------------- busy stall restarts the gap ----------------
        set_cfg(1'b0, 3, 0, 1);
        start_frame = 1'b1;
        tick();
        start_frame = 1'b0;
        tick();
        busy = 1'b1;
        tick_n(4);
        busy = 1'b0;
        c0 = cyc;
        wait_issue("busy");
        check("busy_restart", cyc - c0, 4);
        check_issue("busy", 0, 1, 3);
        tick_n(2);
        check("busy_idle_after_wrap", int'(active), 0);

        // ------------- abort + start_frame during GAP of 3rd issue -------------
        frame_sync_mode = 1'b0;
        set_cfg(1'b0, 4, 2, 2);
        enable = 1'b1;
        wait_issue("ab1");
        check_issue("ab1", 0, 1, 4);
        wait_issue("ab2");
        check_issue("ab2", 1, 1, 4);
        tick_n(2);
        abort = 1'b1;
        start_frame = 1'b1;
        c0 = cyc;
        tick();
        abort = 1'b0;
        start_frame = 1'b0;
        check("ab_idle", int'(active), 0);
        check("ab_outputs_held", int'(segment_num_out), 1);
        wait_issue("ab3");
        check("ab_restart_latency", cyc - c0, 7);
        check_issue("ab3", 0, 1, 4);
        enable = 1'b0;
        tick_n(3);
        check("ab_stop_idle", int'(active), 0);

        // ------------- redundancy 0 behaves as 1; aux wraps 255 -> 0 -------------
        set_cfg(1'b0, 0, 0, 0);
        enable = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 252; i++) begin
            wait_issue("r0");
            if (segment_num_out != 0 || txid_out != 1 || int'(aux_out) != (4 + i) % 256)
                ok = 1'b0;
        end
        check("r0_sequence", int'(ok), 1);
        check("r0_aux_top", int'(aux_out), 255);
        tick_n(2);
        check("r0_cycle_done", int'(cycle_done), 1);
        wait_issue("r0_wrap");
        check_issue("r0_wrap", 0, 1, 0);

        // ------------- reset mid-ISSUE truncates the request -------------
        RST = 1'b1;
        #1;
        check("rst_mid_start_sending", int'(start_sending), 0);
        check("rst_mid_active", int'(active), 0);
        check_issue("rst_mid", 0, 1, 0);
        enable = 1'b0;
        tick_n(2);
        RST = 1'b0;
        tick_n(3);
        check("post_rst_idle", int'(active), 0);
        enable = 1'b1;
        c0 = cyc;
        wait_issue("post_rst");
        check("post_rst_latency", cyc - c0, 2);
        check_issue("post_rst", 0, 1, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
